nearest_hit_sequencer: RTL and testbench



---
 rtl/definitions_pack.sv | 23 ++
 rtl/min_hit_tracker.sv | 41 ++++
 rtl/nearest_hit_sequencer.sv | 97 +++++++++
 tb/tb_nearest_hit_sequencer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/definitions_pack.sv
// definitions_pack: fixed-point, ray/triangle layouts, hit code and FSM states
package definitions_pack;
  localparam int WIDTH = 32;
  localparam int BF = 16;
  typedef logic signed [WIDTH-1:0] fixed_t;
  typedef struct packed {
    fixed_t x;
    fixed_t y;
    fixed_t z;
  } vec_t;
  typedef struct packed {
    vec_t org;
    vec_t dir;
  } ray_t;
  typedef struct packed {
    vec_t v1;
    vec_t v2;
    vec_t v3;
  } tri_t;
  localparam logic [1:0] HIT_CODE = 2'b10;
  localparam fixed_t FIXED_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, ISSUE, WAIT, FIN} state_e;
endpackage

// File: rtl/min_hit_tracker.sv
// min_hit_tracker: running minimum of signed t over hit results; ties keep the earlier index
module min_hit_tracker
  import definitions_pack::*;
#(
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             upd_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [1:0]       code_i,
  input  fixed_t           t_i,
  output logic             hit_o,
  output logic [IDX_W-1:0] hit_idx_o,
  output fixed_t           hit_t_o
);
  logic             hit_q;
  logic [IDX_W-1:0] idx_q;
  fixed_t           t_q;
  logic             take;
  assign take = upd_i && code_i == HIT_CODE && t_i < t_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q <= 1'b0;
      idx_q <= '0;
      t_q   <= '0;
    end else if (clear_i) begin
      hit_q <= 1'b0;
      idx_q <= '0;
      t_q   <= FIXED_MAX;
    end else if (take) begin
      hit_q <= 1'b1;
      idx_q <= idx_i;
      t_q   <= t_i;
    end
  end
  assign hit_o     = hit_q;
  assign hit_idx_o = idx_q;
  assign hit_t_o   = t_q;
endmodule

// File: rtl/nearest_hit_sequencer.sv
// nearest_hit_sequencer: walks a triangle list for one ray, one intersection test
// at a time, and reports the closest valid hit
module nearest_hit_sequencer
  import definitions_pack::*;
#(
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  ray_t             ray_in,
  input  logic [IDX_W:0]   num_tris,
  output logic             busy,
  output logic [IDX_W-1:0] tri_addr,
  output logic             tri_rd,
  input  tri_t             tri_data,
  output logic             it_req,
  input  logic             it_ready,
  output ray_t             it_ray,
  output tri_t             it_trig,
  input  logic             it_res_valid,
  input  logic [WIDTH+1:0] it_res,
  output logic             done,
  output logic             hit,
  output logic [IDX_W-1:0] hit_idx,
  output fixed_t           hit_t
);
  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W:0]   cnt_q, cnt_d, nxt;
  ray_t             ray_d;
  tri_t             trig_d;
  logic             accept, last;
  assign accept = state_q == IDLE && start;
  assign nxt    = {1'b0, idx_q} + 1'b1;
  assign last   = nxt == cnt_q;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ray_d   = it_ray;
    trig_d  = it_trig;
    case (state_q)
      IDLE: if (start) begin
        ray_d   = ray_in;
        cnt_d   = num_tris;
        idx_d   = '0;
        state_d = num_tris == '0 ? FIN : FETCH;
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        trig_d  = tri_data;
        state_d = ISSUE;
      end
      ISSUE: state_d = it_ready ? WAIT : ISSUE;
      WAIT: if (it_res_valid) begin
        state_d = last ? FIN : FETCH;
        idx_d   = last ? idx_q : nxt[IDX_W-1:0];
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      it_ray  <= '0;
      it_trig <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      it_ray  <= ray_d;
      it_trig <= trig_d;
    end
  end
  assign busy     = state_q inside {FETCH, LOAD, ISSUE, WAIT};
  assign tri_rd   = state_q == FETCH;
  assign tri_addr = idx_q;
  assign it_req   = state_q == ISSUE;
  assign done     = state_q == FIN;
  // results arriving outside WAIT (spurious or after an abort) never reach the tracker
  min_hit_tracker #(.IDX_W(IDX_W)) u_min (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (accept),
    .upd_i     (state_q == WAIT && it_res_valid),
    .idx_i     (idx_q),
    .code_i    (it_res[WIDTH+1:WIDTH]),
    .t_i       (it_res[WIDTH-1:0]),
    .hit_o     (hit),
    .hit_idx_o (hit_idx),
    .hit_t_o   (hit_t)
  );
endmodule

// File: tb/tb_nearest_hit_sequencer.sv
// tb_nearest_hit_sequencer: directed and random runs against a list-scan reference model
module tb_nearest_hit_sequencer;
  localparam int IW = 10;
  logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [191:0]  ray_in = '0;
  logic [IW:0]   num_tris = '0;
  logic          busy, tri_rd, it_req, done, hit;
  logic [IW-1:0] tri_addr, hit_idx;
  logic [287:0]  tri_data = '0;
  logic          it_ready = 1'b0, it_res_valid = 1'b0;
  logic [191:0]  it_ray;
  logic [287:0]  it_trig;
  logic [33:0]   it_res = '0;
  logic [31:0]   hit_t;
  nearest_hit_sequencer #(.IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .ray_in(ray_in), .num_tris(num_tris),
    .busy(busy), .tri_addr(tri_addr), .tri_rd(tri_rd), .tri_data(tri_data),
    .it_req(it_req), .it_ready(it_ready), .it_ray(it_ray), .it_trig(it_trig),
    .it_res_valid(it_res_valid), .it_res(it_res), .done(done), .hit(hit),
    .hit_idx(hit_idx), .hit_t(hit_t)
  );
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  logic [287:0] mem [0:15];
  logic [1:0]   codes [0:15];
  logic [31:0]  ts [0:15];
  logic [191:0] ray_exp;
  int lat_cfg = 1, stall_cfg = 0, gen = 0;
  bit spur_cfg = 0;
  // memory + intersection unit model; re-arms itself whenever gen changes
  int gen_seen = 0, pidx = 0, hs = 0, stall_left = 0, dly = 0, trig_bad = 0, stab_bad = 0;
  bit pend = 0, spur = 0, holding = 0;
  logic [287:0] trig_hold;
  logic [191:0] ray_hold;
  int addrs[$];
  always @(negedge clk) begin
    if (gen != gen_seen) begin
      gen_seen = gen; pend = 0; pidx = 0; hs = 0; stall_left = stall_cfg;
      spur = spur_cfg; holding = 0; trig_bad = 0; stab_bad = 0; addrs.delete();
    end
    if (tri_rd) begin
      tri_data = mem[tri_addr[3:0]];
      addrs.push_back(int'(tri_addr));
    end
    it_res_valid = 1'b0;
    if (spur && tri_rd) begin
      it_res_valid = 1'b1; it_res = {2'b10, 32'h8000_0000}; spur = 0;
    end else if (pend) begin
      dly--;
      if (dly == 0) begin
        it_res_valid = 1'b1; it_res = {codes[pidx], ts[pidx]}; pend = 0; pidx++;
      end
    end
    if (it_req) begin
      if (holding && (it_trig !== trig_hold || it_ray !== ray_hold)) stab_bad++;
      if (stall_left > 0) begin
        it_ready = 1'b0; stall_left--; trig_hold = it_trig; ray_hold = it_ray; holding = 1;
      end else begin
        it_ready = 1'b1;
        if (it_trig !== mem[hs] || it_ray !== ray_exp) trig_bad++;
        hs++; pend = 1; dly = lat_cfg; holding = 0;
      end
    end else it_ready = 1'($urandom_range(0, 1));
  end
  task automatic kick(input int n, input int stall, input int l, input bit noise);
    lat_cfg = l; stall_cfg = stall; spur_cfg = noise; gen++;
    ray_exp = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    ray_in = ray_exp; num_tris = (IW+1)'(n); start = 1'b1;
  endtask
  task automatic run(input int n, input int stall, input int l, input bit noise, input string tag);
    int cyc, exp_cyc, eidx;
    bit ehit;
    logic [31:0] et;
    ehit = 0; eidx = 0; et = 32'h7FFF_FFFF;
    for (int i = 0; i < n; i++)
      if (codes[i] == 2'b10 && $signed(ts[i]) < $signed(et)) begin
        ehit = 1; eidx = i; et = ts[i];
      end
    exp_cyc = n == 0 ? 1 : n * (3 + l) + stall + 1;
    kick(n, stall, l, noise);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      start = noise && busy && $urandom_range(0, 2) == 0;
      if (noise) ray_in = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    end while (!done && cyc < 3000);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_cycles"}, cyc, exp_cyc);
    chk({tag, "_busy_fin"}, busy, 0);
    chk({tag, "_hit"}, hit, ehit);
    chk({tag, "_idx"}, hit_idx, eidx);
    chk({tag, "_t"}, hit_t, et);
    chk({tag, "_nreads"}, addrs.size(), n);
    for (int i = 0; i < addrs.size() && i < n; i++) chk({tag, "_addr"}, addrs[i], i);
    chk({tag, "_nreq"}, hs, n);
    chk({tag, "_nres"}, pidx, n);
    chk({tag, "_trig_ray"}, trig_bad, 0);
    chk({tag, "_stable"}, stab_bad, 0);
    start = noise;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_idle"}, {busy, tri_rd}, 0);
    repeat (2) @(negedge clk);
    chk({tag, "_hold_t"}, hit_t, et);
    chk({tag, "_hold_idx"}, hit_idx, eidx);
  endtask
  initial begin
    int nd;
    for (int i = 0; i < 16; i++)
      mem[i] = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_outs", {tri_rd, it_req, done, hit}, 0);
    chk("rst_t", hit_t, 0);
    chk("rst_regs", {it_ray == '0, it_trig == '0, tri_addr == '0, hit_idx == '0}, 4'hF);
    rst = 1'b0;
    @(negedge clk);
    run(0, 0, 1, 0, "empty");
    codes[0] = 2'b00; ts[0] = 32'h0000_0100;
    codes[1] = 2'b10; ts[1] = 32'h0001_8000;
    codes[2] = 2'b10; ts[2] = 32'h0000_8000;
    run(3, 0, 2, 0, "three");
    chk("three_fixed", {hit, 22'(hit_idx), hit_t}, {1'b1, 22'd2, 32'h0000_8000});
    run(3, 5, 2, 0, "stall");
    chk("stall_fixed", {hit, 22'(hit_idx), hit_t}, {1'b1, 22'd2, 32'h0000_8000});
    codes[0] = 2'b11; ts[0] = 32'h0000_1000;
    codes[1] = 2'b10; ts[1] = 32'h0001_0000;
    codes[2] = 2'b01; ts[2] = 32'h0000_0010;
    codes[3] = 2'b10; ts[3] = 32'h0001_0000;
    run(4, 0, 1, 0, "tie");
    chk("tie_fixed", {22'(hit_idx), hit_t}, {22'd1, 32'h0001_0000});
    run(4, 0, 2, 1, "noise");
    chk("noise_fixed", {22'(hit_idx), hit_t}, {22'd1, 32'h0001_0000});
    for (int i = 0; i < 4; i++) begin codes[i] = 2'b10; ts[i] = 32'hFFFF_0000; end
    kick(4, 0, 3, 0);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 200 && !(hs == 2 && pend); k++) @(negedge clk);
    chk("abort_reach", hs, 2);
    @(negedge clk);
    chk("abort_in_wait", {busy, it_req, tri_rd}, 3'b100);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_outs", {tri_rd, it_req, done, hit}, 0);
    chk("abort_t", hit_t, 0);
    chk("abort_regs", {it_ray == '0, it_trig == '0, tri_addr == '0, hit_idx == '0}, 4'hF);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (6) begin @(negedge clk); if (done) nd++; end
    chk("abort_no_done", nd, 0);
    chk("abort_late_res", {hit, hit_t}, 0);
    run(4, 1, 2, 0, "after_rst");
    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        int v;
        codes[i] = $urandom_range(0, 1) ? 2'b10 : 2'($urandom_range(0, 3));
        v = int'($urandom_range(0, 7)) - 4;
        ts[i] = 32'(v * 65536);
      end
      run(n, $urandom_range(0, 4), $urandom_range(1, 3), 1'($urandom_range(0, 1)), "rnd");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
